pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It generates the write-enable and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
- load-use hazards detected at ID/EX;
- taken branches and jumps;
- a variable-latency data-memory handshake, which freezes the pipeline until the memory acknowledges or a timeout fires.

It also keeps saturating stall/flush performance counters.

## Interface
Parameters:
- REG_W, 5, register-index width
- TIMEOUT, 16, maximum memory wait in cycles before error (≥2)
- CNT_W, 32, performance-counter width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous assert, active-low
- ifid_rs_i  in  REG_W  rs of instruction in ID
- ifid_rt_i  in  REG_W  rt of instruction in ID
- ifid_uses_rt_i  in  1  ID instruction reads rt (R-type, beq, sw)
- idex_memread_i  in  1  EX-stage instruction is a load
- idex_rt_i  in  REG_W  destination of EX-stage load
- branch_taken_i  in  1  branch resolved taken in EX
- jump_i  in  1  jump decoded in ID
- mem_req_i  in  1  MEM-stage instruction accesses data memory
- mem_ack_i  in  1  data memory completes access this cycle
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID loads NOP
- idex_write_o  out  1  ID/EX load enable
- idex_flush_o  out  1  ID/EX loads all-zero controls
- exmem_write_o  out  1  EX/MEM load enable
- memwb_bubble_o  out  1  MEM/WB loads RegWrite=0
- mem_timeout_o  out  1  sticky timeout error
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 (excluding ERR)
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1
- state_o  out  2  current FSM state (debug)

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
- Outputs are Mealy, combinational from state and inputs. Default: all write enables 1; flush and bubble 0.
- Hazard priority, highest first: freeze > branch > load-use > jump.
- Freeze applies in RUN when mem_req_i=1 and mem_ack_i=0, and in every MEM_WAIT cycle without ack:
  - pc_write, ifid_write, idex_write, exmem_write = 0;
  - memwb_bubble = 1.
- A cycle with mem_ack_i=1 is never frozen. The pipeline advances and MEM/WB captures the load data.
- Branch (branch_taken_i=1, no freeze): ifid_flush=1, idex_flush=1, pc_write=1 (target loaded).
- Load-use applies when there is no freeze or branch, and all of the following hold:
  - idex_memread_i=1;
  - idex_rt_i≠0;
  - idex_rt_i==ifid_rs_i, or (ifid_uses_rt_i and idex_rt_i==ifid_rt_i).
  - Response: pc_write=0, ifid_write=0, idex_flush=1.
  - Lasts exactly one cycle by construction, because the load moves to MEM.
- Jump (jump_i=1, no higher event): ifid_flush=1 only.
- FSM transitions:
  - RUN→MEM_WAIT: mem_req_i=1 and mem_ack_i=0.
  - MEM_WAIT→RUN: mem_ack_i=1, or mem_req_i=0 (abort, no error).
  - MEM_WAIT→ERR: the wait counter reaches TIMEOUT without ack.
  - ERR is terminal until reset. It keeps the freeze outputs asserted and ignores mem_ack_i; mem_timeout_o=1.
- Wait counter:
  - The RUN cycle that enters the wait counts as wait cycle 1; each MEM_WAIT cycle without ack adds 1.
  - Ack accepted through wait cycle TIMEOUT. With no ack at cycle TIMEOUT, the next state is ERR.
  - Cleared on entering RUN.
- Counters saturate at all-ones, never wrap. Both increment on the same edge if both conditions hold.

## Timing
- Reset (rst_n_i=0), asynchronous:
  - state=RUN, wait counter=0, stall_cnt_o=0, flush_cnt_o=0, mem_timeout_o=0, state_o=0.
  - While in reset: pc/ifid/idex/exmem writes forced 0; ifid_flush, idex_flush, memwb_bubble forced 1 (pipeline holds bubbles).
- Reset asserted mid-wait or in ERR returns to RUN immediately; counters clear.
- Control outputs have zero latency, valid in the same cycle as the inputs.
- Counters, mem_timeout_o and state_o update on the rising edge following the cycle they describe.
- Simultaneous events:
  - branch and load-use: flush wins; no stall counted.
  - mem_req_i and mem_ack_i high in RUN: no freeze, no state change.

## Structure
- Shared header/package pipe_ctrl_pkg holds:
  - state encodings ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_ERR=2'd2;
  - default TIMEOUT.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated twice for the performance counters.
- Hazard comparison stays inline.

## Test plan
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 → pc_write=0, ifid_write=0, idex_flush=1 for one cycle; stall_cnt_o 0→1. Repeat with idex_rt_i=0 → no stall.
- Branch and load-use together: branch_taken_i=1 with the load-use condition true → ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt_o +1, stall_cnt_o unchanged.
- Memory wait, TIMEOUT=4: mem_req_i=1, ack at wait cycle 3 → cycles 1–2 frozen (memwb_bubble=1); cycle 3 all writes 1; state_o back to 0; stall_cnt_o +2.
- Timeout, TIMEOUT=4: mem_req_i held, no ack → cycles 1–4 frozen; state_o=2 and mem_timeout_o=1 from cycle 5; later ack ignored; freeze persists.
- Reset mid-wait: assert rst_n_i=0 in MEM_WAIT → state_o=0, counters=0, forced bubble outputs; after release, an idle pipeline shows all writes 1.
- Saturation, CNT_W=4: 20 consecutive load-use cycles → stall_cnt_o stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose : shared state encodings and defaults for the pipeline hazard controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose : hazard sources from the datapath and the stage-register controls back to it.
// Latency : n/a (wires only).
// Backpressure: controls are the pipeline's backpressure; no handshake of their own.
//   master: pipeline datapath (drives hazard inputs, consumes controls)
//   slave : pipe_hazard_ctrl (consumes hazard inputs, drives controls)
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             ifid_uses_rt_i;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             mem_req_i;
  logic             mem_ack_i;

  logic pc_write_o;
  logic ifid_write_o;
  logic ifid_flush_o;
  logic idex_write_o;
  logic idex_flush_o;
  logic exmem_write_o;
  logic memwb_bubble_o;

  modport master (
    output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, jump_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
           exmem_write_o, memwb_bubble_o
  );

  modport slave (
    input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, jump_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
           exmem_write_o, memwb_bubble_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Purpose : saturating event counter (sticks at all-ones, never wraps).
// Latency : count reflects inc on the following rising edge.
// Backpressure: none; inc is sampled every cycle.
//   ports: clk, rst_n (async active-low), inc, count[W-1:0]
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush sequencer for the 5-stage pipeline (load-use, branch/jump, data-memory wait).
// Latency : controls are combinational (same cycle); counters/state/timeout update on the next edge.
// Backpressure: an un-acked data-memory request freezes every stage until ack, abort or timeout.
//   ports: clk_i, rst_n_i, hif (slave: hazard inputs / stage controls),
//          mem_timeout_o, stall_cnt_o, flush_cnt_o, state_o
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  pipe_hazard_ctrl_if.slave hif,
  output logic              mem_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [1:0]        state_o
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q;
  logic              freeze;
  logic              load_use;

  assign load_use = hif.idex_memread_i && (hif.idex_rt_i != '0) &&
                    ((hif.idex_rt_i == hif.ifid_rs_i) ||
                     (hif.ifid_uses_rt_i && (hif.idex_rt_i == hif.ifid_rt_i)));

  // ERR keeps the pipeline frozen regardless of ack; elsewhere an ack always lets it advance.
  assign freeze = (state_q == ST_ERR) ||
                  ((state_q == ST_RUN) && hif.mem_req_i && !hif.mem_ack_i) ||
                  ((state_q == ST_MEM_WAIT) && !hif.mem_ack_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (state_d == ST_ERR) timeout_q <= 1'b1;
    end
  end

  // wait_cnt_q holds the number of wait cycles already spent; the current cycle is wait_cnt_q+1.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (hif.mem_req_i && !hif.mem_ack_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (hif.mem_ack_i || !hif.mem_req_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    hif.pc_write_o     = 1'b1;
    hif.ifid_write_o   = 1'b1;
    hif.ifid_flush_o   = 1'b0;
    hif.idex_write_o   = 1'b1;
    hif.idex_flush_o   = 1'b0;
    hif.exmem_write_o  = 1'b1;
    hif.memwb_bubble_o = 1'b0;
    if (!rst_n_i) begin
      // hold every stage and fill with bubbles while reset is asserted
      hif.pc_write_o     = 1'b0;
      hif.ifid_write_o   = 1'b0;
      hif.ifid_flush_o   = 1'b1;
      hif.idex_write_o   = 1'b0;
      hif.idex_flush_o   = 1'b1;
      hif.exmem_write_o  = 1'b0;
      hif.memwb_bubble_o = 1'b1;
    end else if (freeze) begin
      hif.pc_write_o     = 1'b0;
      hif.ifid_write_o   = 1'b0;
      hif.idex_write_o   = 1'b0;
      hif.exmem_write_o  = 1'b0;
      hif.memwb_bubble_o = 1'b1;
    end else if (hif.branch_taken_i) begin
      hif.ifid_flush_o = 1'b1;
      hif.idex_flush_o = 1'b1;
    end else if (load_use) begin
      hif.pc_write_o   = 1'b0;
      hif.ifid_write_o = 1'b0;
      hif.idex_flush_o = 1'b1;
    end else if (hif.jump_i) begin
      hif.ifid_flush_o = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (!hif.pc_write_o && (state_q != ST_ERR)),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (hif.ifid_flush_o),
    .count (flush_cnt_o)
  );

  assign mem_timeout_o = timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Latency : controls checked mid-cycle; registered outputs checked after the edge.
// Backpressure: exercises memory freeze, abort, timeout and reset-in-wait.
module tb_pipe_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble}
  localparam logic [6:0] C_RST  = 7'b0010101;
  localparam logic [6:0] C_IDLE = 7'b1101010;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_JMP  = 7'b1111010;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [1:0]       state_o;

  pipe_hazard_ctrl_if #(.REG_W(REG_W)) hif ();

  pipe_hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .hif           (hif.slave),
    .mem_timeout_o (mem_timeout_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic       rst;
    logic [6:0] ctrl;
    logic [1:0] st;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  logic [1:0] prev_st = 2'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check controls mid-cycle
  // and registered outputs just after the edge.
  task automatic step(input string tag, input logic rst,
                      input logic br, input logic jmp, input logic req, input logic ack,
                      input logic memrd, input logic [REG_W-1:0] ex_rt,
                      input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt, input logic uses_rt,
                      input logic [6:0] ec, input logic [1:0] es, input logic eto);
    exp_t e;
    logic [6:0] ctrl;
    rst_n_i            = rst;
    hif.branch_taken_i = br;
    hif.jump_i         = jmp;
    hif.mem_req_i      = req;
    hif.mem_ack_i      = ack;
    hif.idex_memread_i = memrd;
    hif.idex_rt_i      = ex_rt;
    hif.ifid_rs_i      = rs;
    hif.ifid_rt_i      = rt;
    hif.ifid_uses_rt_i = uses_rt;
    e.tag = tag; e.rst = rst; e.ctrl = ec; e.st = es; e.to = eto;
    sb.push_back(e);

    @(negedge clk_i);
    e = sb.pop_front();
    ctrl = {hif.pc_write_o, hif.ifid_write_o, hif.ifid_flush_o, hif.idex_write_o,
            hif.idex_flush_o, hif.exmem_write_o, hif.memwb_bubble_o};
    check_val({e.tag, ".ctrl"}, 32'(ctrl), 32'(e.ctrl));
    if (!e.rst) begin
      exp_stall = 0;
      exp_flush = 0;
      check_val({e.tag, ".rst_state"}, 32'(state_o), 32'd0);
      check_val({e.tag, ".rst_stall"}, 32'(stall_cnt_o), 32'd0);
    end else begin
      if (!e.ctrl[6] && prev_st != 2'd2 && exp_stall != CMAX) exp_stall++;
      if (e.ctrl[4] && exp_flush != CMAX) exp_flush++;
    end

    @(posedge clk_i);
    #1;
    check_val({e.tag, ".state"},   32'(state_o),       32'(e.st));
    check_val({e.tag, ".timeout"}, 32'(mem_timeout_o), 32'(e.to));
    check_val({e.tag, ".stall"},   32'(stall_cnt_o),   32'(exp_stall));
    check_val({e.tag, ".flush"},   32'(flush_cnt_o),   32'(exp_flush));
    prev_st = e.st;
  endtask

  initial begin
    rst_n_i            = 1'b0;
    hif.branch_taken_i = 1'b0;
    hif.jump_i         = 1'b0;
    hif.mem_req_i      = 1'b0;
    hif.mem_ack_i      = 1'b0;
    hif.idex_memread_i = 1'b0;
    hif.idex_rt_i      = '0;
    hif.ifid_rs_i      = '0;
    hif.ifid_rt_i      = '0;
    hif.ifid_uses_rt_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    //   tag            rst br jmp req ack mrd exrt rs  rt  urt ctrl    st  to
    step("reset",        0, 0, 0,  0,  0,  0,  0,   0,  0,  0,  C_RST,  0, 0);
    step("idle",         1, 0, 0,  0,  0,  0,  0,   0,  0,  0,  C_IDLE, 0, 0);
    step("lu_rs",        1, 0, 0,  0,  0,  1,  5,   5,  0,  0,  C_LU,   0, 0);
    step("lu_gone",      1, 0, 0,  0,  0,  0,  5,   5,  0,  0,  C_IDLE, 0, 0);
    step("lu_r0",        1, 0, 0,  0,  0,  1,  0,   0,  0,  1,  C_IDLE, 0, 0);
    step("lu_rt",        1, 0, 0,  0,  0,  1,  7,   3,  7,  1,  C_LU,   0, 0);
    step("lu_rt_unused", 1, 0, 0,  0,  0,  1,  7,   3,  7,  0,  C_IDLE, 0, 0);
    step("br_over_lu",   1, 1, 0,  0,  0,  1,  5,   5,  0,  0,  C_BR,   0, 0);
    step("jump",         1, 0, 1,  0,  0,  0,  0,   0,  0,  0,  C_JMP,  0, 0);
    step("lu_over_jmp",  1, 0, 1,  0,  0,  1,  9,   9,  0,  0,  C_LU,   0, 0);

    step("wait_c1",      1, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  1, 0);
    step("wait_c2",      1, 1, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  1, 0);
    step("wait_ack_c3",  1, 0, 0,  1,  1,  0,  0,   0,  0,  0,  C_IDLE, 0, 0);
    step("req_ack_run",  1, 0, 0,  1,  1,  0,  0,   0,  0,  0,  C_IDLE, 0, 0);
    step("abort_c1",     1, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  1, 0);
    step("abort",        1, 0, 0,  0,  0,  0,  0,   0,  0,  0,  C_FRZ,  0, 0);
    step("after_abort",  1, 0, 1,  0,  0,  0,  0,   0,  0,  0,  C_JMP,  0, 0);

    step("to_c1",        1, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  1, 0);
    step("to_c2",        1, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  1, 0);
    step("to_c3",        1, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  1, 0);
    step("to_c4",        1, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  2, 1);
    step("err_ack",      1, 0, 0,  1,  1,  0,  0,   0,  0,  0,  C_FRZ,  2, 1);
    step("err_idle",     1, 1, 0,  0,  0,  0,  0,   0,  0,  0,  C_FRZ,  2, 1);
    step("err_reset",    0, 0, 0,  0,  0,  0,  0,   0,  0,  0,  C_RST,  0, 0);
    step("post_err",     1, 0, 0,  0,  0,  0,  0,   0,  0,  0,  C_IDLE, 0, 0);

    step("mw_enter",     1, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  1, 0);
    step("mw_c2",        1, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_FRZ,  1, 0);
    step("mw_reset",     0, 0, 0,  1,  0,  0,  0,   0,  0,  0,  C_RST,  0, 0);
    step("mw_release",   1, 0, 0,  0,  0,  0,  0,   0,  0,  0,  C_IDLE, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i), 1, 0, 0, 0, 0, 1, 12, 12, 0, 0, C_LU, 0, 0);
    end
    check_val("sat_final", 32'(stall_cnt_o), 32'(CMAX));
    step("sat_idle",     1, 0, 0,  0,  0,  0,  0,   0,  0,  0,  C_IDLE, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
